// File: rtl/reg_bank_pkg.sv
// +----------------------------------------------------------------------+
// | reg_bank_pkg : shared widths and response record for reg_bank_server |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package reg_bank_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_ack;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/reg_bank_rsp_fifo.sv
// +----------------------------------------------------------------------+
// | reg_bank_rsp_fifo : 2-entry in-order FIFO of rsp_t records           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_bank_rsp_fifo
  import reg_bank_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  rsp_t din_i,
  input  logic pop_i,
  output rsp_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam logic [1:0] c_DEPTH = 2'(DEPTH);

  rsp_t       mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       w_push;
  logic       w_pop;

  assign full_o  = (count_q == c_DEPTH);
  assign empty_o = (count_q == 2'd0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + 2'd1;
    end else if (!w_push && w_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_bank_server.sv
// +----------------------------------------------------------------------+
// | reg_bank_server : handshaked 8x8 register bank, 2 reads + 1 write    |
// | Optional macro REG_ZERO_HARDWIRED_EN makes register 0 constant zero. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module reg_bank_server
  import reg_bank_pkg::*;
#(
  parameter int DATA_W    = reg_bank_pkg::DATA_W,
  parameter int ADDR_W    = reg_bank_pkg::ADDR_W,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_wr_addr,
  input  logic [DATA_W-1:0] req_wr_data,
  input  logic              req_rd_en1,
  input  logic              req_rd_en2,
  input  logic [ADDR_W-1:0] req_rd_addr1,
  input  logic [ADDR_W-1:0] req_rd_addr2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rd_data1,
  output logic [DATA_W-1:0] rsp_rd_data2,
  output logic              rsp_wr_ack,
  output logic [7:0]        wr_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [7:0]        wr_count_q;
  logic [7:0]        wr_count_d;
  logic              w_accept;
  logic              w_wr_ok;
  logic              w_full;
  logic              w_empty;
  rsp_t              w_push_rsp;
  rsp_t              w_head;

  assign req_ready = ~w_full;
  assign w_accept  = req_valid && req_ready;

`ifdef REG_ZERO_HARDWIRED_EN
  assign w_wr_ok = req_wr && (req_wr_addr != '0);
`else
  assign w_wr_ok = req_wr;
`endif

  // Write-first: a read hitting the same request's effective write sees the new data.
  always_comb begin
    w_push_rsp = '0;
    if (req_rd_en1) begin
      w_push_rsp.rd_data1 = (w_wr_ok && (req_rd_addr1 == req_wr_addr)) ? req_wr_data
                                                                        : regs_q[req_rd_addr1];
    end
    if (req_rd_en2) begin
      w_push_rsp.rd_data2 = (w_wr_ok && (req_rd_addr2 == req_wr_addr)) ? req_wr_data
                                                                        : regs_q[req_rd_addr2];
    end
    w_push_rsp.wr_ack = w_wr_ok;
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (w_accept && w_wr_ok && (wr_count_q != 8'hFF)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= 8'd0;
    end else begin
      if (w_accept && w_wr_ok) begin
        regs_q[req_wr_addr] <= req_wr_data;
      end
      wr_count_q <= wr_count_d;
    end
  end

  reg_bank_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_accept),
    .din_i   (w_push_rsp),
    .pop_i   (rsp_ready),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign rsp_valid    = ~w_empty;
  assign rsp_rd_data1 = w_empty ? '0 : w_head.rd_data1;
  assign rsp_rd_data2 = w_empty ? '0 : w_head.rd_data2;
  assign rsp_wr_ack   = w_empty ? 1'b0 : w_head.wr_ack;
  assign wr_count     = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_server.sv
// +----------------------------------------------------------------------+
// | tb_reg_bank_server : vector table + scoreboard bench for the bank    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_reg_bank_server;
  import reg_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [2:0] req_wr_addr = '0;
  logic [7:0] req_wr_data = '0;
  logic       req_rd_en1 = 1'b0;
  logic       req_rd_en2 = 1'b0;
  logic [2:0] req_rd_addr1 = '0;
  logic [2:0] req_rd_addr2 = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rd_data1;
  logic [7:0] rsp_rd_data2;
  logic       rsp_wr_ack;
  logic [7:0] wr_count;

  always #5 clk = ~clk;

  reg_bank_server dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_wr_addr  (req_wr_addr),
    .req_wr_data  (req_wr_data),
    .req_rd_en1   (req_rd_en1),
    .req_rd_en2   (req_rd_en2),
    .req_rd_addr1 (req_rd_addr1),
    .req_rd_addr2 (req_rd_addr2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rd_data1 (rsp_rd_data1),
    .rsp_rd_data2 (rsp_rd_data2),
    .rsp_wr_ack   (rsp_wr_ack),
    .wr_count     (wr_count)
  );

  typedef struct {
    logic       wr;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       e1;
    logic [2:0] a1;
    logic       e2;
    logic [2:0] a2;
    logic [7:0] x1;
    logic [7:0] x2;
    logic       xack;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  rsp_t exp_q[$];
  rsp_t mon_e;
  logic [7:0] m [8];
  int   mcount = 0;
  vec_t tab [13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] wa, input logic [7:0] wd,
                              input logic e1, input logic [2:0] a1, input logic e2,
                              input logic [2:0] a2, input logic [7:0] x1, input logic [7:0] x2,
                              input logic xack);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.e1 = e1; v.a1 = a1; v.e2 = e2; v.a2 = a2;
    v.x1 = x1; v.x2 = x2; v.xack = xack;
    return v;
  endfunction

  // Reference behaviour: returns the expected response and commits the write.
  function automatic rsp_t model(input vec_t v);
    rsp_t e;
    logic wok;
    wok = v.wr;
`ifdef REG_ZERO_HARDWIRED_EN
    if (v.wa == 3'd0) wok = 1'b0;
`endif
    e.rd_data1 = v.e1 ? ((wok && v.a1 == v.wa) ? v.wd : m[v.a1]) : 8'h00;
    e.rd_data2 = v.e2 ? ((wok && v.a2 == v.wa) ? v.wd : m[v.a2]) : 8'h00;
    e.wr_ack   = wok;
    if (wok) begin
      m[v.wa] = v.wd;
      if (mcount < 255) mcount++;
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    mcount = 0;
  endtask

  task automatic send(input vec_t v, input bit use_tab);
    rsp_t e;
    int   n;
    req_valid    = 1'b1;
    req_wr       = v.wr;
    req_wr_addr  = v.wa;
    req_wr_data  = v.wd;
    req_rd_en1   = v.e1;
    req_rd_addr1 = v.a1;
    req_rd_en2   = v.e2;
    req_rd_addr2 = v.a2;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready stayed 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    e = model(v);
    if (use_tab) begin
      e.rd_data1 = v.x1;
      e.rd_data2 = v.x2;
      e.wr_ack   = v.xack;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_wr       = 1'($urandom);
    req_wr_addr  = 3'($urandom);
    req_wr_data  = 8'($urandom);
    req_rd_en1   = 1'($urandom);
    req_rd_en2   = 1'($urandom);
    req_rd_addr1 = 3'($urandom);
    req_rd_addr2 = 3'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got %0h/%0h/%0b, expected no response",
                 rsp_rd_data1, rsp_rd_data2, rsp_wr_ack);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rd_data1", 32'(rsp_rd_data1), 32'(mon_e.rd_data1));
        chk("rsp_rd_data2", 32'(rsp_rd_data2), 32'(mon_e.rd_data2));
        chk("rsp_wr_ack", 32'(rsp_wr_ack), 32'(mon_e.wr_ack));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c0;
    bit   done;
    vec_t v;
    logic [7:0] a0x;
    logic       a0ack;

`ifdef REG_ZERO_HARDWIRED_EN
    a0x = 8'h00; a0ack = 1'b0;
`else
    a0x = 8'hAA; a0ack = 1'b1;
`endif
    tab[0]  = mk(0, 0, 8'h00, 1, 0, 1, 1, 8'h00, 8'h00, 0);
    tab[1]  = mk(0, 0, 8'h00, 1, 2, 1, 3, 8'h00, 8'h00, 0);
    tab[2]  = mk(0, 0, 8'h00, 1, 4, 1, 5, 8'h00, 8'h00, 0);
    tab[3]  = mk(0, 0, 8'h00, 1, 6, 1, 7, 8'h00, 8'h00, 0);
    tab[4]  = mk(1, 1, 8'h03, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    tab[5]  = mk(0, 0, 8'h00, 1, 1, 0, 0, 8'h03, 8'h00, 0);
    tab[6]  = mk(1, 2, 8'h05, 0, 0, 1, 2, 8'h00, 8'h05, 1);
    tab[7]  = mk(1, 0, 8'hAA, 0, 0, 0, 0, 8'h00, 8'h00, a0ack);
    tab[8]  = mk(0, 0, 8'h00, 1, 0, 1, 2, a0x,   8'h05, 0);
    tab[9]  = mk(1, 7, 8'h5A, 1, 7, 1, 1, 8'h5A, 8'h03, 1);
    tab[10] = mk(1, 1, 8'hC3, 1, 1, 0, 1, 8'hC3, 8'h00, 1);
    tab[11] = mk(0, 0, 8'h00, 1, 1, 1, 1, 8'hC3, 8'hC3, 0);
    tab[12] = mk(0, 3, 8'h99, 0, 3, 0, 3, 8'h00, 8'h00, 0);

    model_clear();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rd_data1", 32'(rsp_rd_data1), 32'd0);
    chk("reset_rd_data2", 32'(rsp_rd_data2), 32'd0);
    chk("reset_wr_ack", 32'(rsp_wr_ack), 32'd0);
    chk("reset_wr_count", 32'(wr_count), 32'd0);
    @(posedge clk);
    #1;

    // Table vectors back to back: one accept per cycle.
    c0 = cyc;
    for (int i = 0; i < 13; i++) send(tab[i], 1'b1);
    chk("throughput_cycles", 32'(cyc - c0), 32'd13);
    drain();
    chk("wr_count_table", 32'(wr_count), 32'(mcount));

    // Back-pressure: two accepts fill the buffer, head held stable.
    rsp_ready = 1'b0;
    send(mk(1, 3, 8'h77, 1, 3, 0, 0, 0, 0, 0), 1'b0);
    chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_ready_after1", 32'(req_ready), 32'd1);
    send(mk(1, 4, 8'h88, 1, 3, 1, 4, 0, 0, 0), 1'b0);
    chk("bp_ready_after2", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_head_stable", 32'(rsp_rd_data1), 32'h77);
      chk("bp_head_valid", 32'(rsp_valid), 32'd1);
      chk("bp_ready_held", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    fork
      send(mk(0, 0, 8'h00, 1, 4, 0, 0, 0, 0, 0), 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 rsp_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with two responses buffered.
    rsp_ready = 1'b0;
    send(mk(1, 5, 8'h11, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    send(mk(1, 6, 8'h22, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    chk("pre_reset_full", 32'(req_ready), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_wr_count", 32'(wr_count), 32'd0);
    chk("midreset_rd_data1", 32'(rsp_rd_data1), 32'd0);
    exp_q.delete();
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    send(mk(0, 0, 8'h00, 1, 5, 1, 6, 0, 0, 0), 1'b0);
    send(mk(0, 0, 8'h00, 1, 3, 1, 4, 0, 0, 0), 1'b0);
    drain();

    // Random traffic under random back-pressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          v = mk(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom), 3'($urandom), 0, 0, 0);
          send(v, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    drain();
    chk("wr_count_random", 32'(wr_count), 32'(mcount));

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      send(mk(1, 3'(1 + i % 7), 8'(i), 0, 0, 0, 0, 0, 0, 0), 1'b0);
    end
    drain();
    chk("wr_count_sat", 32'(wr_count), 32'hFF);
    send(mk(0, 0, 8'h00, 1, 7, 1, 1, 0, 0, 0), 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
